// File: rtl/div_seq_pkg.sv
// Shared definitions for the EX-stage sequential divider: FSM states,
// handshake encodings, DIV/DIVU aluop codes and the busy decode.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'd0,
        DIV_BY_ZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_ANNUL            = 1'b1;
    localparam logic DIV_NO_ANNUL         = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // Stall request: a start pending in IDLE already counts as busy so the
    // pipeline freezes on the same cycle EX issues the division.
    function automatic logic busy_of(input div_state_e state, input logic start);
        case (state)
            DIV_FREE: return start;
            DIV_END:  return 1'b0;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Handshake between the EX stage (master) and the sequential divider (slave).
interface div_seq_if #(parameter int WIDTH = 32);

    logic               start_i;
    logic               annul_i;
    logic               signed_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;

    modport master (
        output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o
    );

endinterface

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift {remainder, dividend} left by one,
// trial-subtract the divisor and shift the resulting quotient bit in.
module div_seq_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dvd_next
);

    logic [WIDTH:0] shifted;
    logic           fits;

    assign shifted = {rem, dvd[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, dsr});

    // When the trial subtraction succeeds the difference is below the divisor,
    // so the low WIDTH bits of the subtraction are exact.
    always_comb begin
        if (fits) begin
            rem_next = shifted[WIDTH-1:0] - dsr;
            dvd_next = {dvd[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            dvd_next = {dvd[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU; one quotient bit per clock,
// result {remainder, quotient} held while the issuing instruction waits in EX.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic       clk,
    input logic       rst,
    div_seq_if.slave  bus
);

    div_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dsr;
    logic               neg_dvd;
    logic               neg_dsr;
    logic               is_signed;
    logic [2*WIDTH-1:0] result;
    logic               ready;

    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   dvd_next;
    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               last_step;

    div_seq_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd      (dvd),
        .dsr      (dsr),
        .rem_next (rem_next),
        .dvd_next (dvd_next)
    );

    // NOTE: every variable gets a value on every path of always_comb, otherwise a latch is inferred.
    always_comb begin
        op1_abs   = bus.opdata1_i;
        op2_abs   = bus.opdata2_i;
        if (bus.signed_i && bus.opdata1_i[WIDTH-1]) op1_abs = -bus.opdata1_i;
        if (bus.signed_i && bus.opdata2_i[WIDTH-1]) op2_abs = -bus.opdata2_i;
        // Quotient negative iff signs differ; remainder follows the dividend.
        quo_fix   = (is_signed && (neg_dvd ^ neg_dsr)) ? -dvd_next : dvd_next;
        rem_fix   = (is_signed && neg_dvd) ? -rem_next : rem_next;
        last_step = (cnt == CNT_W'(WIDTH - 1));
    end

    // NOTE: the synchronous reset clears every register, including the datapath, so no stale operand survives a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DIV_FREE;
            cnt       <= '0;
            rem       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            neg_dvd   <= 1'b0;
            neg_dsr   <= 1'b0;
            is_signed <= 1'b0;
            result    <= '0;
            ready     <= DIV_RESULT_NOT_READY;
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            case (state)
                DIV_FREE: begin
                    if (bus.start_i == DIV_START && bus.annul_i == DIV_NO_ANNUL) begin
                        if (bus.opdata2_i == '0) begin
                            state <= DIV_BY_ZERO;
                        end else begin
                            state     <= DIV_ON;
                            dvd       <= op1_abs;
                            dsr       <= op2_abs;
                            neg_dvd   <= bus.opdata1_i[WIDTH-1];
                            neg_dsr   <= bus.opdata2_i[WIDTH-1];
                            is_signed <= bus.signed_i;
                            rem       <= '0;
                            cnt       <= '0;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    state  <= DIV_END;
                    result <= '0;
                    ready  <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (bus.annul_i == DIV_ANNUL) begin
                        state  <= DIV_FREE;
                        result <= '0;
                        ready  <= DIV_RESULT_NOT_READY;
                    end else begin
                        rem <= rem_next;
                        dvd <= dvd_next;
                        cnt <= cnt + CNT_W'(1);
                        if (last_step) begin
                            state  <= DIV_END;
                            result <= {rem_fix, quo_fix};
                            ready  <= DIV_RESULT_READY;
                        end
                    end
                end
                DIV_END: begin
                    if (bus.start_i == DIV_STOP) begin
                        state  <= DIV_FREE;
                        result <= '0;
                        ready  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

    assign bus.result_o = result;
    assign bus.ready_o  = ready;
    assign bus.busy_o   = busy_of(state, bus.start_i);

endmodule
